// File: rtl/tsc_buf_rx.sv
// Receiver for the capture block's buffer dump: requests the buffer, deframes
// the 33-word burst into local memory and tracks peak / first trigger crossing.
module tsc_buf_rx #(
    parameter int         DEPTH       = 32,
    parameter logic [7:0] TRIGVL      = 8'hD5,
    parameter int         REQ_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trd,
    input  logic       cd,
    input  logic [8:0] sd,
    input  logic       ack,
    input  logic [4:0] rd_addr,
    output logic       sbf,
    output logic [7:0] rd_data,
    output logic       done,
    output logic       err,
    output logic [7:0] peak,
    output logic [4:0] peak_idx,
    output logic       trig_found,
    output logic [4:0] trig_idx
);

    localparam int TW = $clog2(REQ_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RECV,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          sbf_q, sbf_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [7:0]    peak_q, peak_d;
    logic [4:0]    peak_idx_q, peak_idx_d;
    logic          trig_found_q, trig_found_d;
    logic [4:0]    trig_idx_q, trig_idx_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          mem_we;

    logic [7:0] mem [DEPTH];

    always_comb begin
        state_d      = state_q;
        sbf_d        = sbf_q;
        done_d       = done_q;
        err_d        = err_q;
        peak_d       = peak_q;
        peak_idx_d   = peak_idx_q;
        trig_found_d = trig_found_q;
        trig_idx_d   = trig_idx_q;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;
        mem_we       = 1'b0;
        rd_data_d    = mem[rd_addr];

        unique case (state_q)
            S_IDLE: begin
                sbf_d = 1'b0;
                if (trd) begin
                    state_d = S_REQ;
                    sbf_d   = 1'b1;
                    tmo_d   = '0;
                end
            end
            S_REQ: begin
                if (!cd) begin
                    sbf_d = 1'b0;
                    if (sd == 9'h001) begin
                        state_d      = S_RECV;
                        cnt_d        = '0;
                        peak_d       = '0;
                        peak_idx_d   = '0;
                        trig_found_d = 1'b0;
                        trig_idx_d   = '0;
                    end else begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                    end
                end else if (tmo_q == TW'(REQ_TIMEOUT - 1)) begin
                    state_d = S_DONE;
                    sbf_d   = 1'b0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_RECV: begin
                if (!cd) begin
                    mem_we = 1'b1;
                    cnt_d  = cnt_q + 5'd1;
                    if (sd[8]) begin
                        err_d = 1'b1;
                    end
                    // strict compare keeps the first occurrence of the maximum
                    if (sd[7:0] > peak_q) begin
                        peak_d     = sd[7:0];
                        peak_idx_d = cnt_q;
                    end
                    if (!trig_found_q && sd[7:0] >= TRIGVL) begin
                        trig_found_d = 1'b1;
                        trig_idx_d   = cnt_q;
                    end
                    if (cnt_q == 5'(DEPTH - 1)) begin
                        state_d = S_CHECK;
                    end
                end else begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                end
            end
            S_CHECK: begin
                if (!cd) begin
                    err_d = 1'b1;
                end
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (ack) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                sbf_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sbf_q        <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            peak_q       <= '0;
            peak_idx_q   <= '0;
            trig_found_q <= 1'b0;
            trig_idx_q   <= '0;
            cnt_q        <= '0;
            tmo_q        <= '0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            sbf_q        <= sbf_d;
            done_q       <= done_d;
            err_q        <= err_d;
            peak_q       <= peak_d;
            peak_idx_q   <= peak_idx_d;
            trig_found_q <= trig_found_d;
            trig_idx_q   <= trig_idx_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Sample memory is not reset; a reset edge also suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[cnt_q] <= sd[7:0];
        end
    end

    assign sbf        = sbf_q;
    assign rd_data    = rd_data_q;
    assign done       = done_q;
    assign err        = err_q;
    assign peak       = peak_q;
    assign peak_idx   = peak_idx_q;
    assign trig_found = trig_found_q;
    assign trig_idx   = trig_idx_q;

endmodule

// File: tb/tb_tsc_buf_rx.sv
// Scoreboard bench for tsc_buf_rx: driver pushes expected frame results and
// read data, a negedge monitor pops and compares as the DUT presents them.
module tb_tsc_buf_rx;

    logic       clk = 1'b0;
    logic       rst, trd, cd, ack;
    logic [8:0] sd;
    logic [4:0] rd_addr;
    logic       sbf, done, err, trig_found;
    logic [7:0] rd_data, peak;
    logic [4:0] peak_idx, trig_idx;

    tsc_buf_rx dut (
        .clk(clk), .rst(rst), .trd(trd), .cd(cd), .sd(sd), .ack(ack),
        .rd_addr(rd_addr), .sbf(sbf), .rd_data(rd_data), .done(done),
        .err(err), .peak(peak), .peak_idx(peak_idx),
        .trig_found(trig_found), .trig_idx(trig_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         dcyc;
        bit         err;
        bit         chk;
        logic [7:0] pk;
        logic [4:0] pki;
        bit         tf;
        logic [4:0] ti;
    } exp_t;

    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    exp_t       exp_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] exp_mem[32];
    logic [7:0] smp[32];
    logic       rd_req = 1'b0;
    logic       rd_req_d = 1'b0;
    logic       done_prev = 1'b0;
    exp_t       me;
    logic [7:0] mr;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rd_req_d <= rd_req;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Monitor: read data one cycle after a request, results on done rise
    always @(negedge clk) begin
        if (rd_req_d) begin
            chk("rd_q_nonempty", (rd_q.size() > 0), 1);
            if (rd_q.size() > 0) begin
                mr = rd_q.pop_front();
                chk("rd_data", rd_data, mr);
            end
        end
        if (done && !done_prev) begin
            chk("exp_q_nonempty", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                me = exp_q.pop_front();
                chk("done_cycle", cyc, me.dcyc);
                chk("err", err, me.err);
                chk("sbf_in_done", sbf, 0);
                if (me.chk) begin
                    chk("peak", peak, me.pk);
                    chk("peak_idx", peak_idx, me.pki);
                    chk("trig_found", trig_found, me.tf);
                    chk("trig_idx", trig_idx, me.ti);
                end
            end
        end
        done_prev <= done;
    end

    // Reference model: whole-frame view over the samples actually sent
    function automatic exp_t model(int n, bit hdr_ok, bit over, int bad8,
                                   int h);
        exp_t e;
        e.chk  = hdr_ok;
        e.dcyc = hdr_ok ? h + ((n < 32) ? n : 32) + 1 : h;
        e.err  = !hdr_ok || (n < 32) || over || (bad8 >= 0 && bad8 < n);
        e.pk   = 8'd0;
        e.pki  = 5'd0;
        e.tf   = 1'b0;
        e.ti   = 5'd0;
        for (int i = 0; i < n; i++)
            if (smp[i] > e.pk) e.pk = smp[i];
        for (int i = 0; i < n; i++)
            if (smp[i] == e.pk) begin
                e.pki = 5'(i);
                break;
            end
        for (int i = 0; i < n; i++)
            if (smp[i] >= 8'hD5) begin
                e.tf = 1'b1;
                e.ti = 5'(i);
                break;
            end
        return e;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic finish_frame(input int raddr);
        int a;
        for (int k = 0; k < 300 && done !== 1'b1; k++) step;
        chk("done_seen", done, 1);
        for (int r = 0; r < 3; r++) begin
            a = (r == 0 && raddr >= 0) ? raddr : int'($urandom_range(0, 31));
            rd_addr = 5'(a);
            rd_q.push_back(exp_mem[a]);
            rd_req = 1'b1;
            step;
        end
        rd_req = 1'b0;
        step;
        ack = 1'b1;
        step;
        ack = 1'b0;
        chk("done_after_ack", done, 0);
        chk("err_after_ack", err, 0);
    endtask

    task automatic drive_frame(input int n, input bit hdr_ok, input bit over,
                               input int bad8, input int rst_at,
                               input int raddr);
        int h;
        trd = 1'b1;
        step;
        trd = 1'b0;
        chk("sbf_rise", sbf, 1);
        repeat ($urandom_range(0, 3)) begin
            step;
            chk("sbf_hold", sbf, 1);
        end
        h = cyc + 1;
        if (rst_at < 0) exp_q.push_back(model(n, hdr_ok, over, bad8, h));
        cd = 1'b0;
        sd = hdr_ok ? 9'h001 : 9'h0AA;
        step;
        chk("sbf_after_hdr", sbf, 0);
        if (hdr_ok) begin
            for (int i = 0; i < n; i++) begin
                sd = {(bad8 == i), smp[i]};
                if (i == rst_at) rst = 1'b1;
                if (rst_at < 0 || i < rst_at) exp_mem[i] = smp[i];
                step;
                if (i == rst_at) begin
                    rst = 1'b0;
                    chk("rst_sbf", sbf, 0);
                    chk("rst_done", done, 0);
                    chk("rst_err", err, 0);
                    chk("rst_peak", peak, 0);
                    chk("rst_peak_idx", peak_idx, 0);
                    chk("rst_trig_found", trig_found, 0);
                    chk("rst_trig_idx", trig_idx, 0);
                    chk("rst_rd_data", rd_data, 0);
                end
            end
            if (over) begin
                sd = {1'b0, 8'h55};
                step;
            end
        end
        cd = 1'b1;
        sd = 9'h000;
        if (rst_at >= 0) begin
            step;
            step;
            chk("ignored_done", done, 0);
            chk("ignored_sbf", sbf, 0);
        end else begin
            finish_frame(raddr);
        end
    endtask

    task automatic timeout_case;
        exp_t e;
        trd = 1'b1;
        step;
        trd = 1'b0;
        chk("tmo_sbf_rise", sbf, 1);
        e.dcyc = cyc + 255;
        e.err  = 1'b1;
        e.chk  = 1'b0;
        e.pk   = 8'd0;
        e.pki  = 5'd0;
        e.tf   = 1'b0;
        e.ti   = 5'd0;
        exp_q.push_back(e);
        for (int k = 0; k < 300 && done !== 1'b1; k++) step;
        chk("tmo_sbf_low", sbf, 0);
        finish_frame(-1);
    endtask

    task automatic rand_smp;
        for (int i = 0; i < 32; i++) smp[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not terminate");
        $fatal(1);
    end

    initial begin
        int n;
        bit ov;
        int b8;
        rst = 1'b1;
        trd = 1'b0;
        cd = 1'b1;
        sd = 9'h000;
        ack = 1'b0;
        rd_addr = 5'd0;
        repeat (3) step;
        chk("reset_sbf", sbf, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_peak", peak, 0);
        chk("reset_peak_idx", peak_idx, 0);
        chk("reset_trig_found", trig_found, 0);
        chk("reset_trig_idx", trig_idx, 0);
        chk("reset_rd_data", rd_data, 0);
        rst = 1'b0;
        step;

        for (int i = 0; i < 32; i++) smp[i] = 8'(4 * i);
        drive_frame(32, 1, 0, -1, -1, 5);

        for (int i = 0; i < 32; i++) smp[i] = 8'h10;
        smp[7] = 8'hD5;
        smp[9] = 8'hF0;
        smp[20] = 8'hF0;
        drive_frame(32, 1, 0, -1, -1, 9);

        rand_smp();
        drive_frame(20, 1, 0, -1, -1, -1);

        drive_frame(32, 0, 0, -1, -1, -1);
        timeout_case();

        rand_smp();
        drive_frame(32, 1, 1, -1, -1, -1);

        rand_smp();
        drive_frame(32, 1, 0, 3, -1, 3);

        rand_smp();
        drive_frame(32, 1, 0, -1, 10, -1);
        rand_smp();
        drive_frame(32, 1, 0, -1, -1, 10);

        for (int f = 0; f < 8; f++) begin
            rand_smp();
            n  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : 32;
            ov = (n == 32) && ($urandom_range(0, 4) == 0);
            b8 = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 31)) : -1;
            drive_frame(n, 1, ov, b8, -1, -1);
        end

        step;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors,
                 miscompares);
        $finish;
    end

endmodule

// File: doc/tsc_buf_rx.md
# tsc_buf_rx

Downstream receiver for the trigger/sample-capture block's buffer dump. It sees the trigger-detected flag, raises the send-buffer request, and deframes the 33-word serial burst (header plus 32 samples) on the `cd`/`sd` lines into a local 32-entry sample memory. It computes the peak sample and the first trigger-crossing index, and exposes the samples to a host through a registered read port. It sits between the capture block and the host/readout logic.

## Interface
- `DEPTH`, 32: samples per frame; fixed at 32, with 5-bit indices.
- `TRIGVL`, 8'hD5: a sample at or above this value counts as a trigger crossing.
- `REQ_TIMEOUT`, 255: maximum cycles spent in REQ waiting for `cd` to fall.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `trd` in 1: trigger detected / buffer ready, from the capture block.
- `cd` in 1: frame strobe; low means a frame word is present on `sd`.
- `sd` in 9: frame word. The header is 9'h001; data words are {1'b0, sample[7:0]}.
- `ack` in 1: host acknowledge. It clears `done`/`err` and re-arms the block.
- `rd_addr` in 5: host read index.
- `sbf` out 1: send-buffer request to the capture block.
- `rd_data` out 8: `mem[rd_addr]`, registered.
- `done` out 1: frame complete; results are valid.
- `err` out 1: frame error; valid while `done`=1.
- `peak` out 8: maximum sample in the frame.
- `peak_idx` out 5: index of the first occurrence of `peak`.
- `trig_found` out 1: at least one sample was >= `TRIGVL`.
- `trig_idx` out 5: index of the first sample >= `TRIGVL`.

## Operation
- **Reset values.** On `rst`=1 at an edge: state IDLE; `sbf`, `done`, `err`, `trig_found` = 0; `peak`, `peak_idx`, `trig_idx`, `rd_data` = 0; count = 0. Memory contents are not reset.
- **Reset mid-operation.** Reset mid-frame takes effect at that edge. Any remaining burst is ignored until IDLE sees `trd`=1 again.
- **IDLE.** `sbf`=0. If `trd`=1, go to REQ and set `sbf` to 1.
- **REQ.** `sbf` is held at 1.
  - `cd`=0 with `sd`==9'h001: go to RECV, set `sbf` to 0, and clear count, `peak`, `peak_idx`, `trig_found`, `trig_idx`.
  - `cd`=0 with any other `sd`: set `err`, set `sbf` to 0, go to DONE.
  - `REQ_TIMEOUT` cycles without `cd`=0: set `err`, set `sbf` to 0, go to DONE.
- **RECV.** On each edge with `cd`=0:
  - `mem[count]` is written with `sd[7:0]`, and count is incremented.
  - If `sd[8]`=1, set `err`; the byte is still stored.
  - Peak update: if `sd[7:0]` > `peak` (strictly greater), set `peak` to the sample and `peak_idx` to count. The first maximum wins.
  - Trigger update: if `trig_found`=0 and `sd[7:0]` >= `TRIGVL`, set `trig_found`=1 and `trig_idx` to count.
  - After the 32nd word (count was 31), go to CHECK.
  - If `cd`=1 while count < 32 (underrun), set `err` and go to DONE.
- **CHECK.** One cycle. If `cd`=0 (overrun), set `err`. Then go to DONE.
- **DONE.** `done`=1 and all results are held. `cd`/`sd` are ignored.
  - `ack`=1: clear `done` and `err`, go to IDLE.
  - If `trd` is still 1 in IDLE, a new request starts.
- **`ack` outside DONE.** No effect.
- **Read port.** Every cycle, `rd_data` is loaded with `mem[rd_addr]`, in every state. A read and a write to the same address in the same cycle return the old data (read-before-write).
- **Index arithmetic.** All indices are 5-bit. Count reaches 32 only as the exit condition and is never used as an address.

## Timing
- `trd` rises before edge E: `sbf`=1 after E.
- Header sampled at edge H: `sbf`=0 after H. Data words are sampled at edges H+1 through H+32.
- With a conforming sender (`cd` rises at H+33): CHECK after H+32, `done`=1 after H+33 with `err`=0.
- Results (`peak`, `trig_*`) are final when `done` rises.
- `rd_data` latency: 1 cycle from `rd_addr`.
- `sbf` is never asserted outside REQ.

## Test plan
- **Conforming frame.** Drive `trd`=1, a header, then samples 0..31 (value = 4×index), then `cd` high. Required: `sbf` high for 1 cycle plus the wait, `done`=1 at H+33, `err`=0, `peak`=124, `peak_idx`=31, `trig_found`=0. Reading `rd_addr`=5 gives 20 one cycle later.
- **Trigger and duplicate peak.** Samples are all 0x10 except idx 7 = 0xD5, idx 9 = 0xF0, idx 20 = 0xF0. Required: `trig_idx`=7, `peak`=0xF0, `peak_idx`=9.
- **Underrun.** `cd` rises after 20 data words. Required: `done`=1, `err`=1 one edge later. Then `ack` → IDLE with `done`=0 and `err`=0.
- **Bad header / timeout.**
  - `sd`=9'h0AA on the first `cd`-low cycle: `err`=1, `done`=1.
  - With `trd`=1 and no `cd` for 255 cycles: `err`=1, `sbf`=0.
- **Overrun and bit-8 error.** `cd` is held low for 34 cycles: `err`=1. A separate frame with `sd[8]`=1 on word 3: `err`=1, and `mem[3]` still holds the byte.
- **Reset mid-frame.** Assert `rst` at data word 10. Required: all outputs are 0 at the next edge; the rest of the burst is ignored; a fresh conforming frame completes with `err`=0.
